imem_port: RTL and testbench

- Responder side of the instruction-fetch interface. Serves the pipeline's fetch request (fetch_addr in, fetch_data/fetch_valid out) from a small word buffer.
- On a buffer miss, issues a single-outstanding read on the instruction memory bus.
- Sits between the fetch stage and the instruction memory/bus arbiter.

---
 rtl/imem_port_pkg.sv | 27 ++
 rtl/imem_port_if.sv | 26 ++
 rtl/imem_word_buffer.sv | 79 +++++++
 rtl/imem_port.sv | 120 ++++++++++++
 tb/tb_imem_port.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/imem_port_pkg.sv
// Shared types and sizes for the instruction-fetch responder.
// IMEM_PORT_PREFETCH_EN selects a two-entry buffer with next-word prefetch.
package imem_port_pkg;
  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;
  localparam int TAG_W       = IMEM_ADDR_W - 2;

`ifdef IMEM_PORT_PREFETCH_EN
  localparam int NUM_ENTRIES = 2;
`else
  localparam int NUM_ENTRIES = 1;
`endif

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic                   valid;
    logic [TAG_W-1:0]       tag;
    logic [IMEM_DATA_W-1:0] data;
    logic                   err;
  } entry_t;

  // Word tags wrap modulo 2^TAG_W.
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return t + 1'b1;
  endfunction
endpackage

// File: rtl/imem_port_if.sv
// Fetch-side and memory-bus signals of imem_port; slave = the responder itself.
interface imem_port_if #(
  parameter int ADDR_W = imem_port_pkg::IMEM_ADDR_W,
  parameter int DATA_W = imem_port_pkg::IMEM_DATA_W
);
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              fetch_error;
  logic              invalidate;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_err;

  modport slave (
    input  fetch_addr, invalidate, mem_ready, mem_rdata, mem_err,
    output fetch_data, fetch_valid, fetch_error, mem_req, mem_addr
  );

  modport master (
    output fetch_addr, invalidate, mem_ready, mem_rdata, mem_err,
    input  fetch_data, fetch_valid, fetch_error, mem_req, mem_addr
  );
endinterface

// File: rtl/imem_word_buffer.sv
// Word buffer: entry storage, combinational hit compare, and (with
// IMEM_PORT_PREFETCH_EN) a 1-bit LRU plus next-word presence check.
module imem_word_buffer import imem_port_pkg::*; (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TAG_W-1:0]       i_tag,
  input  logic                   i_invalidate,
  input  logic                   i_wr_en,
  input  logic [TAG_W-1:0]       i_wr_tag,
  input  logic [IMEM_DATA_W-1:0] i_wr_data,
  input  logic                   i_wr_err,
`ifdef IMEM_PORT_PREFETCH_EN
  input  logic                   i_wr_idx,
  output logic                   o_hit_idx,
  output logic                   o_lru_idx,
  output logic                   o_next_hit,
`endif
  output logic                   o_hit,
  output logic [IMEM_DATA_W-1:0] o_data,
  output logic                   o_err
);
  entry_t                 r_ent [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] w_hit_vec;
  logic [NUM_ENTRIES-1:0] w_wr_sel;

  // Tags are unique across entries, so OR-ing the hitting entry is a clean mux.
  always_comb begin
    w_hit_vec = '0;
    o_data    = '0;
    o_err     = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_hit_vec[i] = r_ent[i].valid && (r_ent[i].tag == i_tag);
      if (w_hit_vec[i]) begin
        o_data = o_data | r_ent[i].data;
        o_err  = o_err  | r_ent[i].err;
      end
    end
  end

  assign o_hit = |w_hit_vec;

`ifdef IMEM_PORT_PREFETCH_EN
  logic             r_lru;
  logic [TAG_W-1:0] w_next_tag;

  assign w_next_tag = next_tag(i_tag);
  assign w_wr_sel   = i_wr_idx ? 2'b10 : 2'b01;
  assign o_hit_idx  = w_hit_vec[1];
  assign o_lru_idx  = r_lru;

  always_comb begin
    o_next_hit = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (r_ent[i].valid && (r_ent[i].tag == w_next_tag)) o_next_hit = 1'b1;
  end

  // A fill makes its entry most-recent; otherwise a demand hit does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        r_lru <= 1'b0;
    else if (i_wr_en && !i_invalidate) r_lru <= ~i_wr_idx;
    else if (o_hit)                   r_lru <= ~o_hit_idx;
  end
`else
  assign w_wr_sel = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (i_invalidate)
          r_ent[i].valid <= 1'b0;
        else if (i_wr_en && w_wr_sel[i])
          r_ent[i] <= '{valid: 1'b1, tag: i_wr_tag, data: i_wr_data, err: i_wr_err};
      end
    end
  end
endmodule

// File: rtl/imem_port.sv
// Instruction-fetch responder: serves fetch from imem_word_buffer and refills it
// with one outstanding bus read. IMEM_PORT_PREFETCH_EN adds next-word prefetch.
module imem_port import imem_port_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input logic         clk,
  input logic         reset,
  imem_port_if.slave  bus
);
  state_e              r_state, w_state_nxt;
  logic                r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [TAG_W-1:0]    r_req_tag, w_req_tag_nxt;
  logic                r_discard, w_discard_nxt;
  logic                w_wr_en;
  logic                w_issue;
  logic [TAG_W-1:0]    w_issue_tag;
  logic [TAG_W-1:0]    w_fetch_tag;
  logic                w_hit;
  logic                w_hit_err;
  logic [DATA_W-1:0]   w_hit_data;
  logic                w_unused;

  assign w_fetch_tag = bus.fetch_addr[ADDR_W-1:2];
  // Byte offset within the word plays no part in a word fetch.
  assign w_unused    = ^bus.fetch_addr[1:0];

`ifdef IMEM_PORT_PREFETCH_EN
  logic w_hit_idx, w_lru_idx, w_next_hit, w_wr_idx;
  // Never overwrite the entry fetch is currently reading from.
  assign w_wr_idx = w_hit ? ~w_hit_idx : w_lru_idx;
`endif

  imem_word_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .i_tag       (w_fetch_tag),
    .i_invalidate(bus.invalidate),
    .i_wr_en     (w_wr_en),
    .i_wr_tag    (r_req_tag),
    .i_wr_data   (bus.mem_rdata),
    .i_wr_err    (bus.mem_err),
`ifdef IMEM_PORT_PREFETCH_EN
    .i_wr_idx    (w_wr_idx),
    .o_hit_idx   (w_hit_idx),
    .o_lru_idx   (w_lru_idx),
    .o_next_hit  (w_next_hit),
`endif
    .o_hit       (w_hit),
    .o_data      (w_hit_data),
    .o_err       (w_hit_err)
  );

  assign bus.fetch_valid = w_hit;
  assign bus.fetch_data  = w_hit_data;
  assign bus.fetch_error = w_hit_err;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_addr    = r_mem_addr;

  always_comb begin
    w_state_nxt    = r_state;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_req_tag_nxt  = r_req_tag;
    w_discard_nxt  = r_discard;
    w_wr_en        = 1'b0;
    w_issue        = 1'b0;
    w_issue_tag    = '0;
    case (r_state)
      IDLE: begin
        // mem_ready here belongs to a request killed by reset; ignore it.
        if (!bus.invalidate) begin
          if (!w_hit) begin
            w_issue     = 1'b1;
            w_issue_tag = w_fetch_tag;
          end
`ifdef IMEM_PORT_PREFETCH_EN
          else if (!w_next_hit) begin
            w_issue     = 1'b1;
            w_issue_tag = next_tag(w_fetch_tag);
          end
`endif
        end
      end
      BUSY: begin
        if (bus.invalidate) w_discard_nxt = 1'b1;
        if (bus.mem_ready) begin
          w_wr_en       = !r_discard && !bus.invalidate;
          w_state_nxt   = IDLE;
          w_mem_req_nxt = 1'b0;
          w_discard_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_issue) begin
      w_state_nxt    = BUSY;
      w_mem_req_nxt  = 1'b1;
      w_mem_addr_nxt = {w_issue_tag, 2'b00};
      w_req_tag_nxt  = w_issue_tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_req_tag  <= '0;
      r_discard  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_req_tag  <= w_req_tag_nxt;
      r_discard  <= w_discard_nxt;
    end
  end
endmodule

// File: tb/tb_imem_port.sv
// Directed bench for imem_port (default build): stimulus queues per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_imem_port;
  logic clk = 1'b0;
  logic reset;
  imem_port_if bus();

  imem_port dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    bit          is_mem;
    logic        v;
    logic [31:0] d;
    logic        e;
    int          id;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   id_no = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_f(input logic v, input logic [31:0] d, input logic e);
    exp_t x;
    x.cyc = cyc; x.is_mem = 1'b0; x.v = v; x.d = d; x.e = e; x.id = id_no++;
    q.push_back(x);
  endtask

  task automatic exp_m(input logic r, input logic [31:0] a);
    exp_t x;
    x.cyc = cyc; x.is_mem = 1'b1; x.v = r; x.d = a; x.e = 1'b0; x.id = id_no++;
    q.push_back(x);
  endtask

  task automatic rsp(input logic rdy, input logic [31:0] d, input logic e);
    bus.mem_ready = rdy;
    bus.mem_rdata = d;
    bus.mem_err   = e;
  endtask

  always @(negedge clk) begin
    exp_t x;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      n_cmp++;
      if (x.cyc != cyc) begin
        n_bad++;
        $display("FAIL stale#%0d expected at cyc %0d, checked at cyc %0d", x.id, x.cyc, cyc);
      end else if (x.is_mem) begin
        if (bus.mem_req !== x.v || bus.mem_addr !== x.d) begin
          n_bad++;
          $display("FAIL mem#%0d cyc=%0d got req=%0b addr=%h want req=%0b addr=%h",
                   x.id, cyc, bus.mem_req, bus.mem_addr, x.v, x.d);
        end
      end else begin
        if (bus.fetch_valid !== x.v || bus.fetch_data !== x.d || bus.fetch_error !== x.e) begin
          n_bad++;
          $display("FAIL fetch#%0d cyc=%0d got v=%0b d=%h e=%0b want v=%0b d=%h e=%0b",
                   x.id, cyc, bus.fetch_valid, bus.fetch_data, bus.fetch_error, x.v, x.d, x.e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; bus.fetch_addr = '0; bus.invalidate = 1'b0; rsp(0, 0, 0);

    // reset state, then zero-wait fill of 0x0
    tick(); exp_m(0, 0); exp_f(0, 0, 0);
    tick(); reset = 1'b0; exp_m(0, 0); exp_f(0, 0, 0);
    tick(); exp_m(1, 0); rsp(1, 32'h0000_0013, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h0000_0013, 0); exp_m(0, 0);

    // 0x100 zero-wait, then 0x104 with three wait cycles
    tick(); bus.fetch_addr = 32'h100; exp_f(0, 0, 0);
    tick(); exp_m(1, 32'h100); rsp(1, 32'hAAAA_0100, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'hAAAA_0100, 0); exp_m(0, 32'h100);
    tick(); bus.fetch_addr = 32'h101; exp_f(1, 32'hAAAA_0100, 0);
    tick(); bus.fetch_addr = 32'h104; exp_f(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_m(1, 32'h104); exp_f(0, 0, 0);
    end
    tick(); exp_m(1, 32'h104); rsp(1, 32'hBBBB_0104, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'hBBBB_0104, 0); exp_m(0, 32'h104);

    // address moves 0x200 -> 0x300 while BUSY
    tick(); bus.fetch_addr = 32'h200; exp_f(0, 0, 0);
    tick(); bus.fetch_addr = 32'h300; exp_m(1, 32'h200); exp_f(0, 0, 0);
    tick(); exp_m(1, 32'h200); rsp(1, 32'hCCCC_0200, 0); exp_f(0, 0, 0);
    tick(); rsp(0, 0, 0); exp_m(0, 32'h200); exp_f(0, 0, 0);
    tick(); exp_m(1, 32'h300); rsp(1, 32'hCCCC_0300, 0); exp_f(0, 0, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'hCCCC_0300, 0);

    // invalidate coincident with mem_ready
    tick(); bus.fetch_addr = 32'h40; exp_f(0, 0, 0);
    tick(); exp_m(1, 32'h40); rsp(1, 32'hDEAD_0040, 0); bus.invalidate = 1'b1;
    tick(); rsp(0, 0, 0); bus.invalidate = 1'b0; exp_f(0, 0, 0); exp_m(0, 32'h40);
    tick(); exp_m(1, 32'h40); rsp(1, 32'hBEEF_0040, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'hBEEF_0040, 0);

    // invalidate earlier in BUSY: response discarded later
    tick(); bus.fetch_addr = 32'h44; exp_f(0, 0, 0);
    tick(); exp_m(1, 32'h44); bus.invalidate = 1'b1;
    tick(); bus.invalidate = 1'b0; rsp(1, 32'h1234_0044, 0); exp_m(1, 32'h44);
    tick(); rsp(0, 0, 0); exp_f(0, 0, 0); exp_m(0, 32'h44);
    tick(); exp_m(1, 32'h44); rsp(1, 32'h5678_0044, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h5678_0044, 0);

    // invalidate in IDLE suppresses the miss; invalidate on a hit
    tick(); bus.fetch_addr = 32'h48; bus.invalidate = 1'b1; exp_f(0, 0, 0);
    tick(); bus.invalidate = 1'b0; exp_m(0, 32'h44);
    tick(); exp_m(1, 32'h48); rsp(1, 32'h9ABC_0048, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h9ABC_0048, 0); bus.invalidate = 1'b1;
    tick(); bus.invalidate = 1'b0; exp_f(0, 0, 0); exp_m(0, 32'h48);
    tick(); exp_m(1, 32'h48); rsp(1, 32'h9ABD_0048, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h9ABD_0048, 0);

    // bus error captured and replayed on hit, no refetch
    tick(); bus.fetch_addr = 32'h80; exp_f(0, 0, 0);
    tick(); exp_m(1, 32'h80); rsp(1, 32'h0BAD_0080, 1);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h0BAD_0080, 1);
    tick(); exp_f(1, 32'h0BAD_0080, 1); exp_m(0, 32'h80);

    // reset while BUSY, stale mem_ready after release
    tick(); bus.fetch_addr = 32'hC0; exp_f(0, 0, 0);
    tick(); exp_m(1, 32'hC0);
    tick(); reset = 1'b1; exp_m(0, 0); exp_f(0, 0, 0);
    tick(); reset = 1'b0; rsp(1, 32'h1111_00C0, 0); exp_m(0, 0); exp_f(0, 0, 0);
    tick(); rsp(0, 0, 0); exp_m(1, 32'hC0); exp_f(0, 0, 0);
    tick(); exp_m(1, 32'hC0); rsp(1, 32'h2222_00C0, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h2222_00C0, 0);

    // top word of the address space, byte offset ignored
    tick(); bus.fetch_addr = 32'hFFFF_FFFF; exp_f(0, 0, 0);
    tick(); exp_m(1, 32'hFFFF_FFFC); rsp(1, 32'h0000_0007, 0);
    tick(); rsp(0, 0, 0); exp_f(1, 32'h0000_0007, 0);
    tick(); bus.fetch_addr = 32'hFFFF_FFFD; exp_f(1, 32'h0000_0007, 0); exp_m(0, 32'hFFFF_FFFC);

    tick();
    tick();
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover %0d expectations unchecked, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
